// File: rtl/bank_alarm_fsm.sv
// Multi-zone bank alarm: arm/disarm FSM with entry delay, sticky trip mask and time-limited siren.
// Optional build macro BANK_ALARM_BLINK_EN makes the active siren toggle every cycle.
module bank_alarm_fsm #(
    parameter int NZONES      = 4,
    parameter int ENTRY_DELAY = 10,
    parameter int SIREN_HOLD  = 20,
    parameter int CW          = 8
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic [NZONES-1:0] zone,
    input  logic              business_hours,
    input  logic              panic,
    input  logic              arm,
    input  logic              disarm,
    output logic              siren,
    output logic [1:0]        state,
    output logic [NZONES-1:0] tripped,
    output logic              arm_err,
    output logic [CW-1:0]     cnt
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        ENTRY    = 2'd2,
        ALARM    = 2'd3
    } state_t;

    localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_DELAY - 1);
    localparam logic [CW-1:0] SIREN_LOAD = CW'(SIREN_HOLD - 1);

    state_t            cur_state, nxt_state;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NZONES-1:0] tripped_q, tripped_d;
    logic              arm_err_q, arm_err_d;
    logic              sounding_q, sounding_d;
`ifdef BANK_ALARM_BLINK_EN
    logic              phase_q, phase_d;
`endif

    always_ff @(posedge clk_2) begin
        if (reset) begin
            cur_state  <= DISARMED;
            cnt_q      <= '0;
            tripped_q  <= '0;
            arm_err_q  <= 1'b0;
            sounding_q <= 1'b0;
`ifdef BANK_ALARM_BLINK_EN
            phase_q    <= 1'b0;
`endif
        end else begin
            cur_state  <= nxt_state;
            cnt_q      <= cnt_d;
            tripped_q  <= tripped_d;
            arm_err_q  <= arm_err_d;
            sounding_q <= sounding_d;
`ifdef BANK_ALARM_BLINK_EN
            phase_q    <= phase_d;
`endif
        end
    end

    // sounding stays high through the cnt==0 cycle so the siren lasts exactly SIREN_HOLD cycles
    always_comb begin
        nxt_state  = cur_state;
        cnt_d      = cnt_q;
        tripped_d  = tripped_q;
        arm_err_d  = 1'b0;
        sounding_d = sounding_q;
`ifdef BANK_ALARM_BLINK_EN
        phase_d    = ~phase_q;
`endif
        if (disarm) begin
            nxt_state  = DISARMED;
            cnt_d      = '0;
            sounding_d = 1'b0;
        end else begin
            if (cur_state == ENTRY || cur_state == ALARM)
                tripped_d = tripped_q | zone;
            if (panic) begin
                nxt_state  = ALARM;
                cnt_d      = SIREN_LOAD;
                sounding_d = 1'b1;
`ifdef BANK_ALARM_BLINK_EN
                phase_d    = 1'b1;
`endif
            end else begin
                case (cur_state)
                    DISARMED: begin
                        if (arm) begin
                            if (zone == '0) begin
                                nxt_state = ARMED;
                                tripped_d = '0;
                            end else begin
                                arm_err_d = 1'b1;
                            end
                        end
                    end
                    ARMED: begin
                        if ((zone != '0) && !business_hours) begin
                            nxt_state = ENTRY;
                            cnt_d     = ENTRY_LOAD;
                            tripped_d = tripped_q | zone;
                        end
                    end
                    ENTRY: begin
                        if (cnt_q == '0) begin
                            nxt_state  = ALARM;
                            cnt_d      = SIREN_LOAD;
                            sounding_d = 1'b1;
`ifdef BANK_ALARM_BLINK_EN
                            phase_d    = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                    ALARM: begin
                        if (cnt_q != '0)
                            cnt_d = cnt_q - CW'(1);
                        else
                            sounding_d = 1'b0;
                    end
                    default: nxt_state = DISARMED;
                endcase
            end
        end
    end

    always_comb begin
`ifdef BANK_ALARM_BLINK_EN
        siren = sounding_q & phase_q;
`else
        siren = sounding_q;
`endif
    end

    assign state   = cur_state;
    assign tripped = tripped_q;
    assign arm_err = arm_err_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_bank_alarm_fsm.sv
// Self-checking bench for bank_alarm_fsm: directed test-plan walk followed by randomized traffic,
// all compared against a countdown-based behavioural model.
module tb_bank_alarm_fsm;

    localparam int NZ = 4;
    localparam int ED = 10;
    localparam int SH = 20;
    localparam int CWID = 8;

    logic            clk_2 = 1'b0;
    logic            reset;
    logic [NZ-1:0]   zone;
    logic            business_hours;
    logic            panic;
    logic            arm;
    logic            disarm;
    logic            siren;
    logic [1:0]      state;
    logic [NZ-1:0]   tripped;
    logic            arm_err;
    logic [CWID-1:0] cnt;

    int check_count = 0;
    int error_count = 0;

    // Model: mode 0..3 plus "cycles left" counters rather than a raw down-counter
    int            m_mode;
    int            m_entry_left;
    int            m_siren_left;
    logic [NZ-1:0] m_tripped;
    logic          m_arm_err;

    bank_alarm_fsm #(.NZONES(NZ), .ENTRY_DELAY(ED), .SIREN_HOLD(SH), .CW(CWID)) dut (
        .clk_2(clk_2),
        .reset(reset),
        .zone(zone),
        .business_hours(business_hours),
        .panic(panic),
        .arm(arm),
        .disarm(disarm),
        .siren(siren),
        .state(state),
        .tripped(tripped),
        .arm_err(arm_err),
        .cnt(cnt)
    );

    always #5 clk_2 = ~clk_2;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int expCnt();
        if (m_mode == 2) return m_entry_left - 1;
        if (m_mode == 3) return (m_siren_left > 0) ? m_siren_left - 1 : 0;
        return 0;
    endfunction

    function automatic logic expSiren();
        if (m_siren_left == 0) return 1'b0;
`ifdef BANK_ALARM_BLINK_EN
        return ((SH - m_siren_left) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic modelStep(input logic r, input logic [NZ-1:0] z, input logic bh,
                             input logic p, input logic a, input logic d);
        m_arm_err = 1'b0;
        if (r) begin
            m_mode = 0; m_entry_left = 0; m_siren_left = 0; m_tripped = '0;
        end else if (d) begin
            m_mode = 0; m_entry_left = 0; m_siren_left = 0;
        end else if (p) begin
            if (m_mode >= 2) m_tripped |= z;
            m_mode = 3; m_siren_left = SH;
        end else begin
            case (m_mode)
                0: if (a) begin
                       if (z == '0) begin m_mode = 1; m_tripped = '0; end
                       else m_arm_err = 1'b1;
                   end
                1: if (z != '0 && !bh) begin
                       m_mode = 2; m_entry_left = ED; m_tripped |= z;
                   end
                2: begin
                       m_tripped |= z;
                       if (m_entry_left == 1) begin m_mode = 3; m_siren_left = SH; end
                       else m_entry_left--;
                   end
                default: begin
                       m_tripped |= z;
                       if (m_siren_left > 0) m_siren_left--;
                   end
            endcase
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [NZ-1:0] z, input logic bh,
                                 input logic p, input logic a, input logic d);
        reset = r; zone = z; business_hours = bh; panic = p; arm = a; disarm = d;
        @(posedge clk_2);
        modelStep(r, z, bh, p, a, d);
        @(negedge clk_2);
        checkOutput("state", 32'(state), 32'(m_mode));
        checkOutput("siren", 32'(siren), 32'(expSiren()));
        checkOutput("tripped", 32'(tripped), 32'(m_tripped));
        checkOutput("arm_err", 32'(arm_err), 32'(m_arm_err));
        checkOutput("cnt", 32'(cnt), 32'(expCnt()));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, '0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; zone = '0; business_hours = 0; panic = 0; arm = 0; disarm = 0;
        m_mode = 0; m_entry_left = 0; m_siren_left = 0; m_tripped = '0; m_arm_err = 0;
        @(negedge clk_2);

        applyStimulus(1, '0, 0, 0, 0, 0);
        applyStimulus(1, '0, 0, 0, 0, 0);
        checkOutput("reset_state", 32'(state), 32'd0);
        applyStimulus(0, '0, 0, 0, 1, 0);
        checkOutput("arm_ok", 32'(state), 32'd1);
        applyStimulus(0, '0, 0, 0, 0, 1);

        applyStimulus(0, 4'b0100, 0, 0, 1, 0);
        checkOutput("arm_refused", 32'(arm_err), 32'd1);
        idle(1);

        // Entry timeout into a latched, time-limited alarm
        applyStimulus(0, '0, 0, 0, 1, 0);
        applyStimulus(0, 4'b0010, 0, 0, 0, 0);
        checkOutput("entry_cnt", 32'(cnt), 32'd9);
        idle(10);
        checkOutput("alarm_reached", 32'(state), 32'd3);
        idle(22);
        checkOutput("alarm_latched", 32'(state), 32'd3);
        applyStimulus(0, '0, 0, 0, 0, 1);

        applyStimulus(0, '0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 4'b1111, 1, 0, 0, 0);
        checkOutput("permitted_state", 32'(state), 32'd1);

        applyStimulus(0, 4'b0001, 0, 0, 0, 0);
        idle(6);
        checkOutput("disarm_at_cnt3", 32'(cnt), 32'd3);
        applyStimulus(0, '0, 0, 0, 0, 1);

        applyStimulus(0, '0, 0, 0, 1, 0);
        applyStimulus(0, 4'b1000, 0, 0, 0, 0);
        applyStimulus(0, '0, 0, 1, 0, 1);
        checkOutput("disarm_beats_panic", 32'(state), 32'd0);

        // Panic from DISARMED, then a reload mid-siren
        applyStimulus(0, '0, 0, 1, 0, 0);
        checkOutput("panic_siren", 32'(siren), 32'd1);
        idle(9);
        applyStimulus(0, '0, 0, 1, 0, 0);
        checkOutput("panic_reload", 32'(cnt), 32'd19);
        idle(22);
        applyStimulus(0, '0, 0, 0, 0, 1);
        applyStimulus(0, 4'b0110, 0, 0, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            logic          r, bh, p, a, d;
            logic [NZ-1:0] z;
            r  = ($urandom_range(0, 199) == 0);
            d  = ($urandom_range(0, 29) == 0);
            p  = ($urandom_range(0, 39) == 0);
            a  = ($urandom_range(0, 3) == 0);
            z  = ($urandom_range(0, 3) == 0) ? NZ'($urandom) : '0;
            bh = 1'($urandom_range(0, 1));
            applyStimulus(r, z, bh, p, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/bank_alarm_fsm.md
Name: bank_alarm_fsm

Overview:
- Sequential, multi-zone successor to the single-door combinational bank alarm.
- Monitors NZONES door/vault sensors, a business-hours time lock and a manual panic switch.
- Runs an arm/disarm state machine with a programmable entry delay, latches which zones tripped, and drives a time-limited siren.
- Instantiated inside top: inputs from SWI, siren/status to LED and SEG, counter values to lcd_* debug outputs.

Parameters:
- NZONES, 4, number of sensor zones (1..8).
- ENTRY_DELAY, 10, clk_2 cycles allowed between a zone opening and the alarm (>=1).
- SIREN_HOLD, 20, clk_2 cycles the siren sounds after entering ALARM (>=1).
- CW, 8, width of the shared down-counter; must satisfy 2^CW > max(ENTRY_DELAY, SIREN_HOLD).

Ports:
- clk_2, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- zone, input, NZONES, 1 = zone door open.
- business_hours, input, 1, 1 = time lock permits zone openings.
- panic, input, 1, manual alarm trigger.
- arm, input, 1, level request to arm.
- disarm, input, 1, level request to disarm; highest priority.
- siren, output, 1, alarm sounder.
- state, output, 2, 0 DISARMED, 1 ARMED, 2 ENTRY, 3 ALARM.
- tripped, output, NZONES, sticky mask of zones that caused ENTRY/ALARM.
- arm_err, output, 1, one-cycle pulse: arm refused.
- cnt, output, CW, current counter value, for the LCD.

Behaviour:
- Clock and reset: one clock, clk_2. Reset is synchronous and active-high: sampled on the clk_2 edge.
- Reset values: state=DISARMED, siren=0, tripped=0, arm_err=0, cnt=0. Reset mid-ENTRY or mid-ALARM aborts immediately on that edge.
- Registered outputs: all outputs are registered. A transition takes effect on the edge where its inputs are sampled, so response latency is 1 cycle.
- Precedence, every cycle: reset > disarm > panic > zone events > arm.
- DISARMED:
  - arm=1 and zone==0 -> ARMED, and tripped cleared.
  - arm=1 and zone!=0 -> stay DISARMED, arm_err=1 for that cycle only.
  - panic=1 -> ALARM, even when disarmed.
- ARMED:
  - disarm -> DISARMED.
  - panic -> ALARM, cnt=SIREN_HOLD-1.
  - Any zone open with business_hours=0 -> ENTRY, cnt=ENTRY_DELAY-1, tripped |= zone.
  - Zone open with business_hours=1 -> remain ARMED; tripped unchanged.
- ENTRY:
  - disarm -> DISARMED, cnt=0.
  - panic -> ALARM, cnt=SIREN_HOLD-1.
  - Otherwise cnt decrements each cycle, and tripped |= zone every cycle.
  - At cnt==0 -> ALARM, cnt=SIREN_HOLD-1.
  - Zones closing does not stop the countdown.
- ALARM:
  - siren=1 while cnt>0 or on the entry cycle; cnt decrements to 0, then siren=0.
  - State stays ALARM (latched) until disarm. tripped keeps accumulating.
  - panic while in ALARM reloads cnt=SIREN_HOLD-1 and re-sounds the siren.
- Simultaneous events:
  - disarm+panic -> DISARMED.
  - arm+disarm in DISARMED -> stay DISARMED, arm_err=0.
  - arm is ignored outside DISARMED.
- Counter rules: cnt never wraps; it saturates at 0. ENTRY_DELAY=1 goes ENTRY->ALARM on the next edge.
- Siren timing: siren is combinationally derived only from registered state/cnt; no input-to-output combinational path.

Optional Feature:
- Macro: BANK_ALARM_BLINK_EN.
- When defined: during siren-active cycles, siren toggles every cycle, starting at 1 on ALARM entry, giving a blinking LED. A panic reload restarts at 1.
- When undefined: siren is steady 1 while active.
- All other outputs are identical in both builds.

Test Plan:
- Reset and arm: reset=1 for 2 cycles -> state=0, siren=0, tripped=0. Then arm=1 with zone=0000 -> state=1 on the next edge, arm_err=0.
- Arm refused: zone=0100, arm=1 -> state stays 0, arm_err=1 for exactly one cycle.
- Entry timeout: armed, business_hours=0, zone=0010 for one cycle.
  - state=2, cnt=9, tripped=0010.
  - After 10 cycles, state=3 and siren=1 for 20 cycles, then siren=0 with state still 3.
  - disarm -> state=0.
- Permitted access: armed, business_hours=1, zone=1111 for 5 cycles -> state stays 1, tripped=0000, siren=0.
- Disarm during entry:
  - Zone 0 opens and the bench disarms at cnt=3 -> state=0, siren never asserted.
  - Separately, disarm and panic on the same cycle -> state=0.
- Panic and blink:
  - DISARMED, panic=1 -> state=3 next edge, siren=1.
  - With BANK_ALARM_BLINK_EN, siren pattern is 1,0,1,0... for 20 cycles.
  - A panic at cycle 10 reloads cnt=19.
